// File: rtl/sd_card_rsp_gen.sv
// SD card-side response generator: serialises 48/136-bit responses on CMD with CRC7, optional DAT0 busy.
// Defining SD_RSP_GEN_ERR_INJECT_EN adds inj_crc_i / inj_end_i for corrupting CRC LSB and end bit.
module sd_card_rsp_gen #(
    parameter int BusyCntWidth = 16,
    parameter int NcrWidth     = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    rsp_long_i,
    input  logic [5:0]              rsp_index_i,
    input  logic [119:0]            rsp_payload_i,
    input  logic                    rsp_no_crc_i,
    input  logic [NcrWidth-1:0]     ncr_cycles_i,
    input  logic [BusyCntWidth-1:0] busy_cycles_i,
`ifdef SD_RSP_GEN_ERR_INJECT_EN
    input  logic                    inj_crc_i,
    input  logic                    inj_end_i,
`endif
    input  logic                    host_cmd_oe_i,
    output logic                    sd_cmd_o,
    output logic                    sd_cmd_oe_o,
    output logic                    sd_dat0_o,
    output logic                    sd_dat0_oe_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    collision_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_NCR, S_SHIFT, S_CRC, S_ENDB, S_BUSY, S_BREL
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              bit_cnt_q, bit_cnt_d;
    logic [NcrWidth-1:0]     ncr_cnt_q, ncr_cnt_d;
    logic [BusyCntWidth-1:0] busy_cnt_q, busy_cnt_d;
    logic [BusyCntWidth-1:0] busy_len_q, busy_len_d;
    logic [127:0]            sreg_q, sreg_d;
    logic [6:0]              crc_q, crc_d;
    logic                    long_q, long_d;
    logic                    no_crc_q, no_crc_d;
    logic                    inj_crc_q, inj_crc_d;
    logic                    inj_end_q, inj_end_d;
    logic                    cmd_d, cmd_oe_d, dat0_d, dat0_oe_d, done_d, coll_d;
    logic [127:0]            frame;
    logic [6:0]              crc_field;
    logic [7:0]              shift_last;
    logic                    inj_crc_in, inj_end_in;

`ifdef SD_RSP_GEN_ERR_INJECT_EN
    assign inj_crc_in = inj_crc_i;
    assign inj_end_in = inj_end_i;
`else
    assign inj_crc_in = 1'b0;
    assign inj_end_in = 1'b0;
`endif

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ncr_cnt_d  = ncr_cnt_q;
        busy_cnt_d = busy_cnt_q;
        busy_len_d = busy_len_q;
        sreg_d     = sreg_q;
        crc_d      = crc_q;
        long_d     = long_q;
        no_crc_d   = no_crc_q;
        inj_crc_d  = inj_crc_q;
        inj_end_d  = inj_end_q;
        cmd_d      = 1'b1;
        cmd_oe_d   = 1'b0;
        dat0_d     = 1'b1;
        dat0_oe_d  = 1'b0;
        done_d     = 1'b0;
        coll_d     = 1'b0;
        frame      = rsp_long_i ? {2'b00, 6'h3F, rsp_payload_i}
                                : {2'b00, rsp_index_i, rsp_payload_i[31:0], 88'd0};
        crc_field  = (no_crc_q ? 7'h7F : crc_q) ^ {6'd0, inj_crc_q};
        shift_last = long_q ? 8'd127 : 8'd39;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    long_d     = rsp_long_i;
                    no_crc_d   = rsp_no_crc_i;
                    busy_len_d = busy_cycles_i;
                    inj_crc_d  = inj_crc_in;
                    inj_end_d  = inj_end_in;
                    bit_cnt_d  = 8'd0;
                    crc_d      = 7'd0;
                    if (ncr_cycles_i == '0) begin
                        state_d  = S_SHIFT;
                        cmd_d    = frame[127];
                        cmd_oe_d = 1'b1;
                        sreg_d   = {frame[126:0], 1'b0};
                        if (!rsp_long_i) crc_d = crc7_step(7'd0, frame[127]);
                    end else begin
                        state_d   = S_NCR;
                        ncr_cnt_d = ncr_cycles_i - NcrWidth'(1);
                        sreg_d    = frame;
                    end
                end
            end
            S_NCR: begin
                if (ncr_cnt_q == '0) begin
                    state_d  = S_SHIFT;
                    cmd_d    = sreg_q[127];
                    cmd_oe_d = 1'b1;
                    sreg_d   = {sreg_q[126:0], 1'b0};
                    if (!long_q) crc_d = crc7_step(crc_q, sreg_q[127]);
                end else begin
                    ncr_cnt_d = ncr_cnt_q - NcrWidth'(1);
                end
            end
            S_SHIFT: begin
                cmd_oe_d = 1'b1;
                if (bit_cnt_q == shift_last) begin
                    state_d   = S_CRC;
                    bit_cnt_d = 8'd0;
                    cmd_d     = crc_field[6];
                    sreg_d    = {crc_field[5:0], 122'd0};
                end else begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    cmd_d     = sreg_q[127];
                    sreg_d    = {sreg_q[126:0], 1'b0};
                    // R2 excludes its 8 header bits from the CRC.
                    if (!long_q || bit_cnt_q >= 8'd7) crc_d = crc7_step(crc_q, sreg_q[127]);
                end
            end
            S_CRC: begin
                cmd_oe_d = 1'b1;
                if (bit_cnt_q == 8'd6) begin
                    state_d = S_ENDB;
                    cmd_d   = ~inj_end_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    cmd_d     = sreg_q[127];
                    sreg_d    = {sreg_q[126:0], 1'b0};
                end
            end
            S_ENDB: begin
                if (busy_len_q != '0) begin
                    state_d    = S_BUSY;
                    dat0_oe_d  = 1'b1;
                    dat0_d     = 1'b0;
                    busy_cnt_d = busy_len_q - BusyCntWidth'(1);
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_BUSY: begin
                dat0_oe_d = 1'b1;
                if (busy_cnt_q == '0) begin
                    state_d = S_BREL;
                end else begin
                    dat0_d     = 1'b0;
                    busy_cnt_d = busy_cnt_q - BusyCntWidth'(1);
                end
            end
            S_BREL: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (host_cmd_oe_i && (state_q inside {S_NCR, S_SHIFT, S_CRC, S_ENDB})) begin
            state_d   = S_IDLE;
            cmd_d     = 1'b1;
            cmd_oe_d  = 1'b0;
            dat0_d    = 1'b1;
            dat0_oe_d = 1'b0;
            done_d    = 1'b0;
            coll_d    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the datapath registers are reset
    // too so no X can ever reach the card pins after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 8'd0;
            ncr_cnt_q    <= '0;
            busy_cnt_q   <= '0;
            busy_len_q   <= '0;
            sreg_q       <= '0;
            crc_q        <= 7'd0;
            long_q       <= 1'b0;
            no_crc_q     <= 1'b0;
            inj_crc_q    <= 1'b0;
            inj_end_q    <= 1'b0;
            sd_cmd_o     <= 1'b1;
            sd_cmd_oe_o  <= 1'b0;
            sd_dat0_o    <= 1'b1;
            sd_dat0_oe_o <= 1'b0;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            collision_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            ncr_cnt_q    <= ncr_cnt_d;
            busy_cnt_q   <= busy_cnt_d;
            busy_len_q   <= busy_len_d;
            sreg_q       <= sreg_d;
            crc_q        <= crc_d;
            long_q       <= long_d;
            no_crc_q     <= no_crc_d;
            inj_crc_q    <= inj_crc_d;
            inj_end_q    <= inj_end_d;
            sd_cmd_o     <= cmd_d;
            sd_cmd_oe_o  <= cmd_oe_d;
            sd_dat0_o    <= dat0_d;
            sd_dat0_oe_o <= dat0_oe_d;
            req_ready_o  <= (state_d == S_IDLE);
            busy_o       <= (state_d != S_IDLE);
            done_o       <= done_d;
            collision_o  <= coll_d;
        end
    end

endmodule

// File: doc/sd_card_rsp_gen.md
Name: sd_card_rsp_gen

Overview:
- Synthesizable SD-card-side response generator that serialises SD command responses onto the CMD line and can signal busy on DAT0.
- Runs in the SD clock domain; clk_i is the card's SD clock.
- Used inside emulated-card test harnesses and FPGA card models attached to the SDHCI host.
- Generalises our response driving:
  - 48-bit (R1/R3/R6/R7) and 136-bit (R2) formats.
  - CRC7 computed internally.
  - Programmable Ncr delay and busy length.
  - Host-collision abort.

Parameters:
BusyCntWidth, 16, width of busy-length counter (max busy = 2^BusyCntWidth-1 cycles)
NcrWidth, 8, width of Ncr delay field

Ports:
clk_i  in  1  SD clock; all state changes on rising edge
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  1  response request valid
req_ready_o  out  1  high only in IDLE
rsp_long_i  in  1  1: 136-bit R2, 0: 48-bit
rsp_index_i  in  6  command index field (48-bit only)
rsp_payload_i  in  120  48-bit: [31:0] = argument/status; 136-bit: [119:0] = CID/CSD bits 127:8
rsp_no_crc_i  in  1  CRC field forced to 7'h7F (R3)
ncr_cycles_i  in  NcrWidth  idle cycles between accept and start bit
busy_cycles_i  in  BusyCntWidth  DAT0 busy length; 0 = no busy
host_cmd_oe_i  in  1  host drives CMD (collision detect)
sd_cmd_o  out  1  CMD line value
sd_cmd_oe_o  out  1  CMD drive enable
sd_dat0_o  out  1  DAT0 value
sd_dat0_oe_o  out  1  DAT0 drive enable
busy_o  out  1  high in any non-IDLE state
done_o  out  1  one-cycle pulse on normal completion
collision_o  out  1  one-cycle pulse on abort

Behaviour:
- All outputs are registered.
- Reset values: sd_cmd_o=1, sd_cmd_oe_o=0, sd_dat0_o=1, sd_dat0_oe_o=0, req_ready_o=1, busy_o=0, done_o=0, collision_o=0, state=IDLE.
- Handshake: the request is accepted in cycle T when req_valid_i && req_ready_o. All inputs are latched at T; later input changes are ignored.
- States: IDLE -> NCR -> SHIFT -> CRC -> ENDB -> (BUSY -> BREL) -> IDLE.
- NCR:
  - Lasts ncr_cycles_i cycles; 0 skips it.
  - sd_cmd_oe_o=0 throughout.
  - The start bit is on the line in cycle T+1+ncr_cycles_i.
- SHIFT, MSB first, sd_cmd_oe_o=1, one bit per cycle:
  - 48-bit: start 0, transmission 0, index[5:0], payload[31:0] (40 bits).
  - 136-bit: start 0, transmission 0, 6'b111111, payload[119:0] (128 bits).
- CRC7:
  - Polynomial x^7+x^3+1, init 0, serial.
  - 48-bit: covers all 40 SHIFT bits.
  - 136-bit: covers only the 120 payload bits.
  - Sent MSB first over 7 cycles; replaced by 7'h7F when rsp_no_crc_i.
- ENDB: one cycle of 1.
  - sd_cmd_oe_o drops the next cycle.
  - Total driven length: exactly 48 or 136 cycles.
- BUSY (only if busy_cycles_i != 0):
  - Starts the cycle after the end bit: sd_dat0_oe_o=1, sd_dat0_o=0 for busy_cycles_i cycles.
  - BREL: one cycle with sd_dat0_o=1 driven, then sd_dat0_oe_o=0.
- done_o pulses in the cycle the FSM re-enters IDLE:
  - After BREL if busy was used.
  - Otherwise, the cycle after ENDB.
  - req_ready_o rises in the same cycle.
- Bit counter: 8-bit, saturating is not required (max index 135).
- Collision:
  - Trigger: host_cmd_oe_i=1 in any cycle in NCR, SHIFT, CRC or ENDB.
  - Next cycle: sd_cmd_oe_o=0, sd_dat0_oe_o=0, sd_cmd_o=1, collision_o pulses, FSM returns to IDLE.
  - done_o is not pulsed.
  - host_cmd_oe_i is ignored in BUSY/BREL and IDLE.
- req_valid_i while busy_o: not accepted, no side effect.
- Reset mid-operation: all outputs return to reset values immediately (async). No done_o or collision_o pulse.

Optional Feature:
- Macro: SD_RSP_GEN_ERR_INJECT_EN
- Defined:
  - Adds inputs inj_crc_i and inj_end_i (1 bit each), latched at accept.
  - inj_crc_i inverts the LSB of the transmitted CRC field (also under rsp_no_crc_i).
  - inj_end_i sends end bit 0.
  - Length and timing are unchanged.
- Undefined: ports absent; CRC and end bit always correct.

Test Plan:
- R7, rsp_long_i=0, index 8, payload 32'h000001AA, ncr 2, busy 0 -> start bit at T+3; 48 bits equal 0x08_00_00_01_AA_13; sd_cmd_oe_o low at T+51; done_o at T+51.
- R3, rsp_no_crc_i=1, index 6'h3F, payload 32'h80FF8000 -> CRC field 7'h7F, end bit 1, 48 driven cycles.
- R2, rsp_long_i=1, payload random -> 136 driven cycles; bits 133:128 all 1; CRC equals the bench CRC7 over the payload only; done_o once.
- R1 with busy_cycles 10, ncr 0 -> DAT0 low for exactly 10 cycles after the end bit, then 1 driven for one cycle, then oe 0; done_o in the next cycle.
- host_cmd_oe_i pulsed during bit 20 of SHIFT -> oe low the next cycle, collision_o pulse, no done_o; a new request is accepted the cycle after.
- rst_i asserted during BUSY -> sd_dat0_oe_o=0 and req_ready_o=1 asynchronously; no done_o.
- With SD_RSP_GEN_ERR_INJECT_EN: R7 above with inj_crc_i=1 -> last byte 0x11; with inj_end_i=1 -> last byte 0x12.
